// File: rtl/operand_fetch_stage_pkg.sv
// Shared widths, the operand bundle type and the bypass resolution helper
// for the decode-to-execute operand fetch stage.
package operand_fetch_stage_pkg;

  localparam int REG_ADDR_W    = 5;
  localparam int XLEN          = 32;
  localparam int NUM_REGS      = 32;
  localparam int BUNDLE_CTRL_W = 8;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [BUNDLE_CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]          op1;
    logic [XLEN-1:0]          op2;
    logic [XLEN-1:0]          imm;
    logic [REG_ADDR_W-1:0]    rd;
    logic                     rd_we;
  } operand_bundle_t;

  // x0 reads as zero; a same-cycle writeback beats the stale register file value.
  function automatic logic [XLEN-1:0] resolve_operand(
    input logic [REG_ADDR_W-1:0] src,
    input logic                  wb_en,
    input logic [REG_ADDR_W-1:0] wb_addr,
    input logic [XLEN-1:0]       wb_data,
    input logic [XLEN-1:0]       rf_data
  );
    if (src == ZERO_REG)
      return '0;
    else if (wb_en && (wb_addr == src))
      return wb_data;
    else
      return rf_data;
  endfunction

endpackage

// File: rtl/operand_fetch_stage_hazard_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set on issue,
// cleared by writeback or by killing the issued instruction; combinational busy lookups.
module hazard_scoreboard
  import operand_fetch_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_addr,
  input  logic                  kill_en,
  input  logic [REG_ADDR_W-1:0] kill_addr,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  busy1,
  output logic                  busy2
);

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;

  // Later statements win: issue overrides writeback, kill overrides issue.
  always_comb begin
    pending_d = pending_q;
    if (wb_en)
      pending_d[wb_addr] = 1'b0;
    if (set_en && (set_addr != ZERO_REG))
      pending_d[set_addr] = 1'b1;
    if (kill_en && (kill_addr != ZERO_REG))
      pending_d[kill_addr] = 1'b0;
    pending_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      pending_q <= '0;
    else
      pending_q <= pending_d;
  end

  assign busy1 = (rs1 != ZERO_REG) && pending_q[rs1];
  assign busy2 = (rs2 != ZERO_REG) && pending_q[rs2];

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch: reads the register file, applies writeback bypass, stalls on RAW hazards.
// One cycle from accept to out_valid; accepts only when the output slot is free or draining.
module operand_fetch_stage
  import operand_fetch_stage_pkg::*;
#(
  parameter int CTRL_W = BUNDLE_CTRL_W,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_W-1:0]     in_ctrl,
  input  logic [REG_ADDR_W-1:0] in_rs1,
  input  logic [REG_ADDR_W-1:0] in_rs2,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_rd_we,
  input  logic [XLEN-1:0]       in_imm,
  output logic [REG_ADDR_W-1:0] readAddr1,
  output logic [REG_ADDR_W-1:0] readAddr2,
  input  logic [XLEN-1:0]       rf_data1,
  input  logic [XLEN-1:0]       rf_data2,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_W-1:0]     out_ctrl,
  output logic [XLEN-1:0]       out_op1,
  output logic [XLEN-1:0]       out_op2,
  output logic [XLEN-1:0]       out_imm,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_rd_we,
  output logic [CNT_W-1:0]      stall_cnt
);

  operand_bundle_t bundle_q;
  operand_bundle_t bundle_d;
  logic            valid_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic            busy1;
  logic            busy2;
  logic            hazard1;
  logic            hazard2;
  logic            hazard;
  logic            fire;
  logic            kill_en;

  assign readAddr1 = in_rs1;
  assign readAddr2 = in_rs2;

  hazard_scoreboard u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .set_en    (fire && in_rd_we),
    .set_addr  (in_rd),
    .kill_en   (kill_en),
    .kill_addr (bundle_q.rd),
    .rs1       (in_rs1),
    .rs2       (in_rs2),
    .busy1     (busy1),
    .busy2     (busy2)
  );

  // A pending source being written back this cycle is covered by the bypass.
  assign hazard1 = busy1 && !(wb_en && (wb_addr == in_rs1));
  assign hazard2 = busy2 && !(wb_en && (wb_addr == in_rs2));
  assign hazard  = in_valid && (hazard1 || hazard2);

  assign in_ready = (!valid_q || out_ready) && !hazard && !flush;
  assign fire     = in_valid && in_ready;
  assign kill_en  = flush && valid_q && bundle_q.rd_we;

  always_comb begin
    bundle_d       = bundle_q;
    bundle_d.ctrl  = BUNDLE_CTRL_W'(in_ctrl);
    bundle_d.op1   = resolve_operand(in_rs1, wb_en, wb_addr, wb_data, rf_data1);
    bundle_d.op2   = resolve_operand(in_rs2, wb_en, wb_addr, wb_data, rf_data2);
    bundle_d.imm   = in_imm;
    bundle_d.rd    = in_rd;
    bundle_d.rd_we = in_rd_we;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
    end else if (flush) begin
      valid_q  <= 1'b0;
    end else if (fire) begin
      valid_q  <= 1'b1;
      bundle_q <= bundle_d;
    end else if (out_ready) begin
      valid_q  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt_q <= '0;
    else if (hazard && (stall_cnt_q != '1))
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
  end

  assign out_valid = valid_q;
  assign out_ctrl  = CTRL_W'(bundle_q.ctrl);
  assign out_op1   = bundle_q.op1;
  assign out_op2   = bundle_q.op2;
  assign out_imm   = bundle_q.imm;
  assign out_rd    = bundle_q.rd;
  assign out_rd_we = bundle_q.rd_we;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Decode-to-execute boundary stage of the 32-bit core.
- Takes a decoded instruction, drives the register file read ports, and merges register-file data with a writeback bypass.
- Holds a 32-entry pending-write scoreboard and stalls on read-after-write hazards.
- Presents a registered, valid/ready operand bundle to the execute stage.

Parameters:
CTRL_W, 8, width of the opaque decoded control field passed through to execute
CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
in_valid  input  1  decoded instruction present
in_ready  output  1  stage accepts the instruction this cycle
in_ctrl  input  CTRL_W  decoded control, passed through
in_rs1  input  5  source register 1
in_rs2  input  5  source register 2
in_rd  input  5  destination register
in_rd_we  input  1  instruction writes in_rd
in_imm  input  32  immediate, passed through
readAddr1  output  5  register file read address 1 (= in_rs1)
readAddr2  output  5  register file read address 2 (= in_rs2)
rf_data1  input  32  register file read data 1
rf_data2  input  32  register file read data 2
wb_en  input  1  writeback this cycle (same signal as the register file writeEn)
wb_addr  input  5  writeback address
wb_data  input  32  writeback data
flush  input  1  kill the instruction held in this stage
out_valid  output  1  operand bundle valid
out_ready  input  1  execute stage accepts the bundle
out_ctrl  output  CTRL_W  registered in_ctrl
out_op1  output  32  resolved operand 1
out_op2  output  32  resolved operand 2
out_imm  output  32  registered in_imm
out_rd  output  5  registered in_rd
out_rd_we  output  1  registered in_rd_we
stall_cnt  output  CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Reset (rst=0, asynchronous): all out_* registers = 0, out_valid=0, scoreboard=0, stall_cnt=0.
- readAddr1/2 are combinational copies of in_rs1/in_rs2.
- Operand resolution, per source s, combinational:
  - s==0 -> 0.
  - else wb_en && wb_addr==s -> wb_data.
  - else rf_data.
- Hazard, per source: s!=0 && sb[s]==1 && !(wb_en && wb_addr==s). hazard = in_valid && (hazard_rs1 || hazard_rs2).
- in_ready = (!out_valid || out_ready) && !hazard && !flush.
- fire = in_valid && in_ready.
- Output register, priority order:
  - flush -> out_valid<=0.
  - else fire -> load all out_* fields, out_valid<=1.
  - else out_ready -> out_valid<=0.
  - else hold.
- Latency: one cycle from fire to out_valid.
- Held bundle: out_* fields stay stable while out_valid && !out_ready.
- Scoreboard, per entry r each cycle:
  - Clear when wb_en && wb_addr==r.
  - Set when fire && in_rd_we && in_rd==r && r!=0.
  - Set wins over clear on the same entry.
  - Flush clears sb[out_rd] if out_valid && out_rd_we && out_rd!=0.
  - Flush has priority over a same-cycle set on that entry. No set can occur during flush, since in_ready=0.
- sb[0] is never set.
- stall_cnt increments each cycle that in_valid && hazard. It saturates at all-ones.
- in_ready depends on in_rs1/in_rs2. Upstream must hold its fields stable while in_valid && !in_ready.
- Reset mid-operation: the in-flight bundle and all pending scoreboard bits are discarded.

Decomposition:
- Shared package holds:
  - REG_ADDR_W=5, XLEN=32, NUM_REGS=32.
  - The constant ZERO_REG=0.
  - A packed typedef for the operand bundle {ctrl, op1, op2, imm, rd, rd_we}.
- One sub-module, hazard_scoreboard:
  - Holds the 32-bit pending vector with its set/clear/flush-clear logic.
  - Exposes combinational busy lookups for rs1/rs2.

Test Plan:
- Reset then idle:
  - Stimulus: rst low 3 cycles, then high.
  - Response: out_valid=0, in_ready=1, stall_cnt=0.
- Plain issue:
  - Stimulus: rf_data1=0x11, rf_data2=0x22, in_rs1=3, in_rs2=4, in_rd=5, in_rd_we=1, in_imm=0x7, out_ready=1.
  - Response: next cycle out_op1=0x11, out_op2=0x22, out_rd=5, out_valid=1, sb[5]=1.
- RAW stall then bypass:
  - Stimulus: sb[5]=1, next instruction rs1=5, wb_en held low 3 cycles.
  - Response: in_ready=0 for 3 cycles and stall_cnt=3.
  - Stimulus: then wb_en=1, wb_addr=5, wb_data=0xABCD.
  - Response: fire, out_op1=0xABCD, sb[5]=0.
- Register zero:
  - Stimulus: in_rs1=0 with rf_data1=0xFFFFFFFF, in_rd=0, in_rd_we=1.
  - Response: out_op1=0, sb stays 0, no stall.
- Backpressure:
  - Stimulus: out_ready=0 with out_valid=1, new in_valid.
  - Response: in_ready=0 and out_* unchanged for 4 cycles.
  - Stimulus: out_ready=1.
  - Response: next bundle loads the following cycle.
- Flush and simultaneous set/clear:
  - Stimulus: flush with out_rd=7, out_rd_we=1.
  - Response: out_valid=0, sb[7]=0.
  - Stimulus: fire with in_rd=9 while wb_en=1, wb_addr=9.
  - Response: sb[9]=1.
